// File: rtl/dcache_coh_ctrl_pkg.sv
// rtl/dcache_coh_ctrl_pkg.sv - shared MSI, FSM and fill-source encodings for dcache_coh_ctrl
package dcache_coh_ctrl_pkg;

    localparam int NUM_LINES = 8;
    localparam int IDX_W     = 3;
    localparam int TAG_W     = 10;
    localparam int ADDR_W    = IDX_W + TAG_W;

    typedef enum logic [1:0] {
        MSI_I = 2'b00,
        MSI_S = 2'b01,
        MSI_M = 2'b10
    } msi_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        FILL = 2'b10,
        UPG  = 2'b11
    } coh_st_t;

    localparam logic [1:0] SOURCE_DMEM       = 2'b00;
    localparam logic [1:0] SOURCE_OTHER_PROC = 2'b01;
    localparam logic [1:0] SOURCE_NONE       = 2'b11;

endpackage

// File: rtl/dcache_coh_ctrl_coh_tag_array.sv
// rtl/dcache_coh_ctrl_coh_tag_array.sv - 8-entry tag/MSI store, CPU and snoop read ports, one prioritised write port
module coh_tag_array
    import dcache_coh_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] cpu_idx,
    output logic [TAG_W-1:0] cpu_tag,
    output msi_t             cpu_st,
    input  logic [IDX_W-1:0] snp_idx,
    output logic [TAG_W-1:0] snp_tag,
    output msi_t             snp_st,
    input  logic             snp_wr,
    input  msi_t             snp_wst,
    input  logic             fill_wr,
    input  logic [IDX_W-1:0] fill_idx,
    input  logic [TAG_W-1:0] fill_tag,
    input  msi_t             fill_wst
);

    logic [TAG_W-1:0] tags   [NUM_LINES];
    msi_t             states [NUM_LINES];

    assign cpu_tag = tags[cpu_idx];
    assign cpu_st  = states[cpu_idx];
    assign snp_tag = tags[snp_idx];
    assign snp_st  = states[snp_idx];

    // Single write port: snoop state changes take precedence over fills and upgrades
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                tags[i]   <= '0;
                states[i] <= MSI_I;
            end
        end else if (snp_wr) begin
            states[snp_idx] <= snp_wst;
        end else if (fill_wr) begin
            tags[fill_idx]   <= fill_tag;
            states[fill_idx] <= fill_wst;
        end
    end

endmodule

// File: rtl/dcache_coh_ctrl.sv
// rtl/dcache_coh_ctrl.sv - MSI data-cache coherence controller; COH_PERF_EN adds hit/miss counters
module dcache_coh_ctrl
    import dcache_coh_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_stall,
    output logic              read_miss,
    output logic              write_miss,
    output logic              invalidate,
    output logic [ADDR_W-1:0] BICO,
    input  logic              grant,
    input  logic [1:0]        datasel,
    input  logic              u_rdy,
    input  logic              search,
    input  logic [ADDR_W-1:0] BOCI,
    output logic              search_found,
    input  logic              inv_from_other,
`ifdef COH_PERF_EN
    output logic [15:0]       hit_cnt,
    output logic [15:0]       miss_cnt,
`endif
    output logic [1:0]        block_state
);

    coh_st_t           state;
    logic [ADDR_W-1:0] lat_addr;
    logic              lat_we;

    logic [TAG_W-1:0]  cpu_line_tag, snp_line_tag;
    msi_t              cpu_line_st, snp_line_st;
    logic              access, tag_hit, hit, wr_upg, collide, idle_acc, hit_ok, miss_go;
    logic              snp_match, snp_wr, fill_done, upg_inv, fill_wr;
    msi_t              snp_wst, fill_wst;

    coh_tag_array u_tags (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_idx  (cpu_addr[IDX_W-1:0]),
        .cpu_tag  (cpu_line_tag),
        .cpu_st   (cpu_line_st),
        .snp_idx  (BOCI[IDX_W-1:0]),
        .snp_tag  (snp_line_tag),
        .snp_st   (snp_line_st),
        .snp_wr   (snp_wr),
        .snp_wst  (snp_wst),
        .fill_wr  (fill_wr),
        .fill_idx (lat_addr[IDX_W-1:0]),
        .fill_tag (lat_addr[ADDR_W-1:IDX_W]),
        .fill_wst (fill_wst)
    );

    // CPU-side lookup; a same-index snoop in the same cycle defers the access by one cycle
    assign access   = cpu_re | cpu_we;
    assign tag_hit  = (cpu_line_tag == cpu_addr[ADDR_W-1:IDX_W]) && (cpu_line_st != MSI_I);
    assign hit      = tag_hit && (!cpu_we || (cpu_line_st == MSI_M));
    assign wr_upg   = tag_hit && cpu_we && (cpu_line_st == MSI_S);
    assign collide  = (search | inv_from_other) && (BOCI[IDX_W-1:0] == cpu_addr[IDX_W-1:0]);
    assign idle_acc = (state == IDLE) && access && !collide;
    assign hit_ok   = idle_acc && hit;
    assign miss_go  = idle_acc && !hit;

    assign cpu_stall = rst_n && access && !hit_ok;
    assign BICO      = !rst_n ? '0 : (state != IDLE) ? lat_addr : cpu_addr;

    // Snoop-side lookup and the state change it implies
    assign snp_match    = (snp_line_tag == BOCI[ADDR_W-1:IDX_W]);
    assign search_found = search && snp_match && (snp_line_st != MSI_I);
    assign block_state  = snp_match ? snp_line_st : MSI_I;
    assign snp_wr       = snp_match && (snp_line_st != MSI_I) &&
                          (inv_from_other || (search && (snp_line_st == MSI_M)));
    assign snp_wst      = inv_from_other ? MSI_I : MSI_S;

    // Fill/upgrade commit waits whenever a snoop owns the write port
    assign fill_done = grant && ((datasel != SOURCE_NONE) || u_rdy);
    assign upg_inv   = inv_from_other && (BOCI == lat_addr);
    assign fill_wr   = !snp_wr && (((state == FILL) && fill_done) ||
                                   ((state == UPG) && grant && !upg_inv));
    assign fill_wst  = (lat_we || (state == UPG)) ? MSI_M : MSI_S;

    // Miss/upgrade sequencer with registered bus request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_addr   <= '0;
            lat_we     <= 1'b0;
            read_miss  <= 1'b0;
            write_miss <= 1'b0;
            invalidate <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_go) begin
                        lat_addr <= cpu_addr;
                        lat_we   <= cpu_we;
                        if (wr_upg) begin
                            state      <= UPG;
                            invalidate <= 1'b1;
                        end else begin
                            state      <= REQ;
                            read_miss  <= !cpu_we;
                            write_miss <= cpu_we;
                        end
                    end
                end
                REQ: begin
                    if (grant) begin
                        state      <= FILL;
                        read_miss  <= 1'b0;
                        write_miss <= 1'b0;
                    end
                end
                FILL: begin
                    if (fill_wr) state <= IDLE;
                end
                UPG: begin
                    if (upg_inv) begin
                        state      <= REQ;
                        invalidate <= 1'b0;
                        write_miss <= 1'b1;
                        lat_we     <= 1'b1;
                    end else if (fill_wr) begin
                        state      <= IDLE;
                        invalidate <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef COH_PERF_EN
    logic miss_evt;
    assign miss_evt = (miss_go && !wr_upg) || ((state == UPG) && upg_inv);

    // Saturating counters of IDLE hits and entries into REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (hit_ok && (hit_cnt != 16'hFFFF))    hit_cnt  <= hit_cnt + 16'd1;
            if (miss_evt && (miss_cnt != 16'hFFFF)) miss_cnt <= miss_cnt + 16'd1;
        end
    end
`else
    // hit/miss counters are absent in this build
`endif

endmodule
